lru_tracker: RTL and testbench

Parametrised least-recently-used tracker for N_BTN push-buttons with a DEPTH-entry recency queue.
Each button press is one access. Each LED shows whether its button is currently held in the queue.
When a new ID is inserted into a full queue, the least recent ID is evicted and reported.
Runs in the slow timer clock domain. Supersedes the fixed 4-button/3-slot tracker and adds true move-to-front, selectable FIFO mode, eviction reporting and clear.

---
 rtl/lru_tracker_pkg.sv | 17 +
 rtl/lru_tracker_if.sv | 28 ++
 rtl/lru_tracker_press_detect.sv | 56 +++++
 rtl/lru_tracker.sv | 153 +++++++++++++++
 tb/tb_lru_tracker.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lru_tracker_pkg.sv
// Shared types and constants for the LRU button tracker.
package lru_tracker_pkg;

  typedef enum logic [0:0] {
    MODE_LRU  = 1'b0,
    MODE_FIFO = 1'b1
  } lru_mode_e;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACCESS = 2'd2
  } lru_state_e;

  localparam int unsigned EMPTY_ID = 0;

endpackage

// File: rtl/lru_tracker_if.sv
// Button/LED bus of the LRU tracker; the tracker is the slave side.
interface lru_tracker_if #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned ID_W  = $clog2(N_BTN + 1),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);

  logic [N_BTN-1:0] btn;
  logic             clr;
  logic [N_BTN-1:0] led;
  logic [ID_W-1:0]  mru_id;
  logic             evict_valid;
  logic [ID_W-1:0]  evict_id;
  logic [CNT_W-1:0] count;
  logic             full;

  modport master (
    output btn, clr,
    input  led, mru_id, evict_valid, evict_id, count, full
  );

  modport slave (
    input  btn, clr,
    output led, mru_id, evict_valid, evict_id, count, full
  );

endinterface

// File: rtl/lru_tracker_press_detect.sv
// Rising-edge press detector with lowest-ID priority and a one-deep pending slot
// that holds a press arriving while the consumer is busy.
module lru_press_detect
  import lru_tracker_pkg::*;
#(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned ID_W  = $clog2(N_BTN + 1)
) (
  input  logic             timedClk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  input  logic             i_clr,
  input  logic             i_ready,
  output logic             o_press_valid_c,
  output logic [ID_W-1:0]  o_press_id_c
);

  logic [N_BTN-1:0] r_btn_q;
  logic             r_pend_valid;
  logic [ID_W-1:0]  r_pend_id;

  logic [N_BTN-1:0] w_rise;
  logic             w_new_valid;
  logic [ID_W-1:0]  w_new_id;
  logic             w_take;

  // Lowest rising bit wins; the other simultaneous risers are simply dropped.
  always_comb begin
    w_rise      = i_btn & ~r_btn_q;
    w_new_valid = |w_rise;
    w_new_id    = ID_W'(EMPTY_ID);
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (w_rise[i]) w_new_id = ID_W'(i + 1);
    end
  end

  // A pending press is older than a fresh one, so it is offered first.
  assign o_press_valid_c = r_pend_valid | w_new_valid;
  assign o_press_id_c    = r_pend_valid ? r_pend_id : w_new_id;
  assign w_take          = i_ready & o_press_valid_c;

  always_ff @(posedge timedClk) begin
    r_btn_q <= i_btn;
    if (rst || i_clr) begin
      r_pend_valid <= 1'b0;
      r_pend_id    <= ID_W'(EMPTY_ID);
    end else if (w_take) begin
      r_pend_valid <= r_pend_valid & w_new_valid;
      r_pend_id    <= (r_pend_valid & w_new_valid) ? w_new_id : ID_W'(EMPTY_ID);
    end else if (!r_pend_valid && w_new_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_id    <= w_new_id;
    end
  end

endmodule

// File: rtl/lru_tracker.sv
// Recency queue of button IDs with move-to-front (LRU) or insertion-order (FIFO)
// policy, eviction reporting and LED presence decode.
module lru_tracker
  import lru_tracker_pkg::*;
#(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned DEPTH = 3,
  parameter lru_mode_e   MODE  = MODE_LRU,
  parameter int unsigned ID_W  = $clog2(N_BTN + 1),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         timedClk,
  input  logic         rst,
  lru_tracker_if.slave bus
);

  lru_state_e       r_state;
  logic [ID_W-1:0]  r_slot [DEPTH];
  logic [ID_W-1:0]  r_acc_id;
  logic [CNT_W-1:0] r_count;
  logic [N_BTN-1:0] r_led;
  logic [ID_W-1:0]  r_mru;
  logic             r_full;
  logic             r_ev_valid;
  logic [ID_W-1:0]  r_ev_id;

  logic             w_ready;
  logic             w_press_valid;
  logic [ID_W-1:0]  w_press_id;
  logic             w_hit;
  logic [CNT_W-1:0] w_hit_pos;
  logic [ID_W-1:0]  w_slot_nxt [DEPTH];
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ev_valid;
  logic [ID_W-1:0]  w_ev_id;
  logic [N_BTN-1:0] w_led_nxt;
  logic             w_full_nxt;

  assign w_ready = (r_state == S_IDLE) && !bus.clr;

  lru_press_detect #(
    .N_BTN (N_BTN),
    .ID_W  (ID_W)
  ) u_press_detect (
    .timedClk        (timedClk),
    .rst             (rst),
    .i_btn           (bus.btn),
    .i_clr           (bus.clr),
    .i_ready         (w_ready),
    .o_press_valid_c (w_press_valid),
    .o_press_id_c    (w_press_id)
  );

  // Empty slots hold 0 and an access ID is never 0, so they never match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_pos = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_slot[i] == r_acc_id && r_acc_id != ID_W'(EMPTY_ID)) begin
        w_hit     = 1'b1;
        w_hit_pos = CNT_W'(i);
      end
    end
  end

  // Queue update for the latched access, plus decode of the resulting queue.
  always_comb begin
    w_slot_nxt = r_slot;
    w_cnt_nxt  = r_count;
    w_ev_valid = 1'b0;
    w_ev_id    = ID_W'(EMPTY_ID);
    if (!w_hit) begin
      for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
        w_slot_nxt[i] = r_slot[i-1];
      end
      w_slot_nxt[0] = r_acc_id;
      if (r_count == CNT_W'(DEPTH)) begin
        w_ev_valid = 1'b1;
        w_ev_id    = r_slot[DEPTH-1];
      end else begin
        w_cnt_nxt = r_count + CNT_W'(1);
      end
    end else if (MODE == MODE_LRU) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (i <= int'(w_hit_pos)) w_slot_nxt[i] = r_slot[i-1];
      end
      w_slot_nxt[0] = r_acc_id;
    end

    w_led_nxt = '0;
    for (int k = 1; k <= int'(N_BTN); k++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_slot_nxt[i] == ID_W'(k)) w_led_nxt[k-1] = 1'b1;
      end
    end
    w_full_nxt = (w_cnt_nxt == CNT_W'(DEPTH));
  end

  // Control FSM; queue state and all outputs change only at the commit edge.
  always_ff @(posedge timedClk) begin
    if (rst) begin
      r_state    <= S_INIT;
      for (int i = 0; i < int'(DEPTH); i++) r_slot[i] <= ID_W'(EMPTY_ID);
      r_acc_id   <= ID_W'(EMPTY_ID);
      r_count    <= '0;
      r_led      <= '0;
      r_mru      <= ID_W'(EMPTY_ID);
      r_full     <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev_id    <= ID_W'(EMPTY_ID);
    end else begin
      r_ev_valid <= 1'b0;
      r_ev_id    <= ID_W'(EMPTY_ID);
      if (bus.clr) begin
        r_state <= S_IDLE;
        for (int i = 0; i < int'(DEPTH); i++) r_slot[i] <= ID_W'(EMPTY_ID);
        r_count <= '0;
        r_led   <= '0;
        r_mru   <= ID_W'(EMPTY_ID);
        r_full  <= 1'b0;
      end else begin
        case (r_state)
          S_INIT: r_state <= S_IDLE;
          S_IDLE: begin
            if (w_press_valid) begin
              r_acc_id <= w_press_id;
              r_state  <= S_ACCESS;
            end
          end
          S_ACCESS: begin
            r_slot     <= w_slot_nxt;
            r_count    <= w_cnt_nxt;
            r_led      <= w_led_nxt;
            r_mru      <= w_slot_nxt[0];
            r_full     <= w_full_nxt;
            r_ev_valid <= w_ev_valid;
            r_ev_id    <= w_ev_id;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_INIT;
        endcase
      end
    end
  end

  assign bus.led         = r_led;
  assign bus.mru_id      = r_mru;
  assign bus.full        = r_full;
  assign bus.count       = r_count;
  assign bus.evict_valid = r_ev_valid;
  assign bus.evict_id    = r_ev_id;

endmodule

// File: tb/tb_lru_tracker.sv
// Bench for lru_tracker: one LRU and one FIFO instance on shared stimulus,
// each checked against a queue-based recency model.
module tb_lru_tracker;
  import lru_tracker_pkg::*;

  localparam int unsigned N_BTN = 4;
  localparam int unsigned DEPTH = 3;

  logic timedClk = 1'b0;
  logic rst;
  logic [N_BTN-1:0] btn;
  logic clr;

  always #5 timedClk = ~timedClk;

  lru_tracker_if #(.N_BTN(N_BTN), .DEPTH(DEPTH)) bus_l ();
  lru_tracker_if #(.N_BTN(N_BTN), .DEPTH(DEPTH)) bus_f ();

  assign bus_l.btn = btn;
  assign bus_l.clr = clr;
  assign bus_f.btn = btn;
  assign bus_f.clr = clr;

  lru_tracker #(.N_BTN(N_BTN), .DEPTH(DEPTH), .MODE(MODE_LRU)) u_lru (
    .timedClk (timedClk),
    .rst      (rst),
    .bus      (bus_l)
  );

  lru_tracker #(.N_BTN(N_BTN), .DEPTH(DEPTH), .MODE(MODE_FIFO)) u_fifo (
    .timedClk (timedClk),
    .rst      (rst),
    .bus      (bus_f)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: most recent first.
  int ql[$];
  int qf[$];
  int ev_l, evid_l, ev_f, evid_f;
  logic [N_BTN-1:0] btn_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_BTN-1:0] led_of(input int q[$]);
    logic [N_BTN-1:0] r;
    r = '0;
    foreach (q[i]) r[q[i]-1] = 1'b1;
    return r;
  endfunction

  function automatic int mru_of(input int q[$]);
    return (q.size() != 0) ? q[0] : 0;
  endfunction

  task automatic model_clear();
    ql.delete();
    qf.delete();
    ev_l = 0; evid_l = 0; ev_f = 0; evid_f = 0;
  endtask

  task automatic model_access(input int k);
    int idx[$];
    ev_l = 0; evid_l = 0; ev_f = 0; evid_f = 0;
    idx = ql.find_first_index(x) with (x == k);
    if (idx.size() != 0) begin
      ql.delete(idx[0]);
      ql.push_front(k);
    end else begin
      ql.push_front(k);
      if (ql.size() > int'(DEPTH)) begin ev_l = 1; evid_l = ql.pop_back(); end
    end
    idx = qf.find_first_index(x) with (x == k);
    if (idx.size() == 0) begin
      qf.push_front(k);
      if (qf.size() > int'(DEPTH)) begin ev_f = 1; evid_f = qf.pop_back(); end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, " lru.led"},   32'(bus_l.led),         32'(led_of(ql)));
    check_eq({tag, " lru.mru"},   32'(bus_l.mru_id),      32'(mru_of(ql)));
    check_eq({tag, " lru.count"}, 32'(bus_l.count),       32'(ql.size()));
    check_eq({tag, " lru.full"},  32'(bus_l.full),        32'(ql.size() == int'(DEPTH)));
    check_eq({tag, " lru.ev"},    32'(bus_l.evict_valid), 32'(ev_l));
    check_eq({tag, " lru.evid"},  32'(bus_l.evict_id),    32'(evid_l));
    check_eq({tag, " fifo.led"},  32'(bus_f.led),         32'(led_of(qf)));
    check_eq({tag, " fifo.mru"},  32'(bus_f.mru_id),      32'(mru_of(qf)));
    check_eq({tag, " fifo.count"},32'(bus_f.count),       32'(qf.size()));
    check_eq({tag, " fifo.full"}, 32'(bus_f.full),        32'(qf.size() == int'(DEPTH)));
    check_eq({tag, " fifo.ev"},   32'(bus_f.evict_valid), 32'(ev_f));
    check_eq({tag, " fifo.evid"}, 32'(bus_f.evict_id),    32'(evid_f));
  endtask

  // Apply btn/clr at one edge, hold btn for n_hold edges, then update model and check.
  task automatic step(input string tag, input logic [N_BTN-1:0] b, input logic c, input int n_hold);
    logic [N_BTN-1:0] rise;
    int k;
    @(negedge timedClk);
    btn = b;
    clr = c;
    @(posedge timedClk);
    #1 clr = 1'b0;
    repeat (n_hold - 1) @(posedge timedClk);
    @(negedge timedClk);
    ev_l = 0; evid_l = 0; ev_f = 0; evid_f = 0;
    rise = b & ~btn_prev;
    btn_prev = b;
    if (c) begin
      model_clear();
    end else if (rise != '0) begin
      k = 0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (rise[i] && k == 0) k = i + 1;
      end
      model_access(k);
    end
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    btn = 4'b0001;
    model_clear();
    repeat (3) @(posedge timedClk);
    @(negedge timedClk);
    rst = 1'b0;
    btn_prev = 4'b0001;
    repeat (2) @(negedge timedClk);
    check_all("reset");
    check_eq("reset led", 32'(bus_l.led), 32'(0));

    // Held-through-reset button: no access until released and pressed again.
    step("release1", 4'b0000, 1'b0, 2);
    step("repress1", 4'b0001, 1'b0, 2);
    check_eq("repress1 count", 32'(bus_l.count), 32'(1));
    step("hold1",    4'b0001, 1'b0, 4);
    step("clear",    4'b0000, 1'b1, 2);

    // Fill, then evict, then hit.
    step("p1", 4'b0001, 1'b0, 2);
    step("r",  4'b0000, 1'b0, 2);
    step("p2", 4'b0010, 1'b0, 2);
    step("r",  4'b0000, 1'b0, 2);
    step("p3", 4'b0100, 1'b0, 2);
    check_eq("p3 led",  32'(bus_l.led),  32'(4'b0111));
    check_eq("p3 full", 32'(bus_l.full), 32'(1));
    step("r",  4'b0000, 1'b0, 2);
    step("p4", 4'b1000, 1'b0, 2);
    check_eq("p4 evid", 32'(bus_l.evict_id), 32'(1));
    check_eq("p4 led",  32'(bus_l.led),      32'(4'b1110));
    step("r",  4'b0000, 1'b0, 2);
    step("hit2", 4'b0010, 1'b0, 2);
    check_eq("hit2 lru mru",  32'(bus_l.mru_id), 32'(2));
    check_eq("hit2 fifo mru", 32'(bus_f.mru_id), 32'(4));
    step("r",  4'b0000, 1'b0, 2);
    step("p1b", 4'b0001, 1'b0, 2);
    check_eq("p1b lru evid", 32'(bus_l.evict_id), 32'(3));

    // Two simultaneous risers: only ID 1 is accepted.
    step("clear", 4'b0000, 1'b1, 2);
    step("multi", 4'b0101, 1'b0, 5);
    check_eq("multi led", 32'(bus_l.led), 32'(4'b0001));
    step("r", 4'b0000, 1'b0, 2);

    // Clear beats a press of 4 on a full queue.
    step("p2", 4'b0010, 1'b0, 2);
    step("r",  4'b0000, 1'b0, 2);
    step("p3", 4'b0100, 1'b0, 2);
    step("r",  4'b0000, 1'b0, 2);
    step("p1", 4'b0001, 1'b0, 2);
    step("r",  4'b0000, 1'b0, 2);
    check_eq("prefull full", 32'(bus_l.full), 32'(1));
    step("clrpress", 4'b1000, 1'b1, 2);
    check_eq("clrpress count", 32'(bus_l.count),       32'(0));
    check_eq("clrpress ev",    32'(bus_l.evict_valid), 32'(0));

    // Press arriving during an access is held pending, then serviced.
    step("clear", 4'b0000, 1'b1, 2);
    @(negedge timedClk); btn = 4'b0001;
    @(posedge timedClk);
    @(negedge timedClk); btn = 4'b0011;
    @(posedge timedClk);
    @(negedge timedClk);
    model_access(1);
    check_all("pend first");
    @(posedge timedClk);
    @(posedge timedClk);
    @(negedge timedClk);
    model_access(2);
    check_all("pend second");
    btn_prev = 4'b0011;

    // Reset while an access is in flight.
    @(negedge timedClk); btn = 4'b0111;
    @(posedge timedClk);
    @(negedge timedClk); rst = 1'b1;
    @(posedge timedClk);
    @(negedge timedClk);
    model_clear();
    check_all("rst access");
    rst = 1'b0;
    btn_prev = 4'b0111;
    repeat (3) @(negedge timedClk);
    check_all("post rst");

    // Randomized presses with occasional clear.
    for (int n = 0; n < 300; n++) begin
      step("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
